piso_serializer: RTL and testbench



---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_bit_counter.sv | 43 ++++
 rtl/piso_serializer.sv | 158 +++++++++++++++
 tb/tb_piso_serializer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
// Holds the FSM state type, the frame-length helper and the default word width.
// No logic of its own; imported by piso_serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int PISO_DEFAULT_WIDTH = 16;

    // Bits per frame: the data word plus one trailing parity bit when enabled.
    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: loadable (clear-to-zero) up-counter with terminal flags.
// Latency: registered count, flags are combinational decodes of the count.
// Backpressure: none; holds at FRAME_LEN-1 and never wraps on its own.
module piso_bit_counter #(
    parameter int FRAME_LEN = 16,
    parameter int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o,
    output logic          pre_last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment; saturate at the last bit index.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign last_o     = (cnt_q == CW'(FRAME_LEN - 1));
    assign pre_last_o = (cnt_q == CW'(FRAME_LEN - 2));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer feeding a downstream serial-in shift register.
// Latency: first bit on ser_out one cycle after the accept edge; one bit per cycle.
// Backpressure: in_ready only in IDLE or on the last frame bit. Optional parity: PISO_PARITY_EN.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
    localparam int CW        = $clog2(FRAME_LEN + 1);

    piso_state_t      state_q;
    piso_state_t      state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             ser_out_q;
    logic             ser_out_d;
    logic             frame_done_q;
    logic             frame_done_d;

    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             cnt_pre_last;
    logic             cnt_clr;
    logic             cnt_en;
    logic             xfer;

    logic             in_head;
    logic [WIDTH-1:0] in_rest;
    logic             sreg_head;
    logic [WIDTH-1:0] sreg_rest;
    logic             next_is_parity;
    logic             parity_bit;

    // The word is held pre-shifted: the bit going out next always sits at the head.
    if (MSB_FIRST) begin : g_msb_first
        assign in_head   = in_data[WIDTH-1];
        assign in_rest   = {in_data[WIDTH-2:0], 1'b0};
        assign sreg_head = sreg_q[WIDTH-1];
        assign sreg_rest = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
        assign in_head   = in_data[0];
        assign in_rest   = {1'b0, in_data[WIDTH-1:1]};
        assign sreg_head = sreg_q[0];
        assign sreg_rest = {1'b0, sreg_q[WIDTH-1:1]};
    end

`ifdef PISO_PARITY_EN
    logic parity_q;

    // Even parity of the accepted word, sent after the last data bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (xfer) begin
            parity_q <= ^in_data;
        end
    end

    assign parity_bit     = parity_q;
    assign next_is_parity = (cnt == CW'(WIDTH - 1));
`else
    assign parity_bit     = 1'b0;
    assign next_is_parity = 1'b0;
`endif

    // Ready when idle, or while the last bit is on the wire so frames can abut.
    assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_last);
    assign xfer     = in_valid && in_ready;

    // Counter tracks the index of the bit currently on ser_out; it restarts on
    // every accept and returns to zero when the frame ends without a follow-on.
    assign cnt_clr = xfer || cnt_last;
    assign cnt_en  = (state_q == SHIFT);

    piso_bit_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CW        (CW)
    ) u_bit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .cnt_o      (cnt),
        .last_o     (cnt_last),
        .pre_last_o (cnt_pre_last)
    );

    // State register: reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start on accept, leave after the last bit unless a new word lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = SHIFT;
            SHIFT:   if (cnt_last && !xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: load on accept, otherwise shift until the last bit.
    always_comb begin
        sreg_d       = sreg_q;
        ser_out_d    = 1'b0;
        frame_done_d = 1'b0;
        if (xfer) begin
            sreg_d    = in_rest;
            ser_out_d = in_head;
        end else if ((state_q == SHIFT) && !cnt_last) begin
            sreg_d       = sreg_rest;
            ser_out_d    = next_is_parity ? parity_bit : sreg_head;
            frame_done_d = cnt_pre_last;
        end
    end

    // Registered serial outputs and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q       <= '0;
            ser_out_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sreg_q       <= sreg_d;
            ser_out_q    <= ser_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = (state_q == SHIFT);
    assign busy       = (state_q == SHIFT);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus.
// A queue model holds the bits still to appear on the wire for each instance.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_piso_serializer;

    localparam int W = 16;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;

    logic rdy_m, so_m, sv_m, fd_m, bz_m;
    logic rdy_l, so_l, sv_l, fd_l, bz_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (rdy_m),
        .ser_out    (so_m),
        .ser_valid  (sv_m),
        .frame_done (fd_m),
        .busy       (bz_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (rdy_l),
        .ser_out    (so_l),
        .ser_valid  (sv_l),
        .frame_done (fd_l),
        .busy       (bz_l)
    );

    int       n_vec = 0;
    int       n_err = 0;
    bit       qm[$];
    bit       ql[$];
    bit       hist[$];
    logic [15:0] sr = '0;
    logic [15:0] sr_at_done = '0;
    int       run = 0;
    int       maxrun = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) qm.push_back(w[i]);
        for (int i = 0; i < W; i++) ql.push_back(w[i]);
`ifdef PISO_PARITY_EN
        qm.push_back(^w);
        ql.push_back(^w);
`endif
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (qm.size() > 0);
        chk("msb_valid", sv_m, ev);
        chk("msb_busy",  bz_m, ev);
        chk("msb_out",   so_m, ev ? qm[0] : 1'b0);
        chk("msb_done",  fd_m, qm.size() == 1);
        chk("msb_ready", rdy_m, qm.size() <= 1);
        chk("lsb_valid", sv_l, ev);
        chk("lsb_out",   so_l, (ql.size() > 0) ? ql[0] : 1'b0);
        chk("lsb_done",  fd_l, ql.size() == 1);
        chk("lsb_ready", rdy_l, ql.size() <= 1);
        if (sv_m) run++;
        else run = 0;
        if (run > maxrun) maxrun = run;
    endtask

    // One clock: apply inputs, advance the model at the edge, check at the falling edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        logic        ov, ob, acc, was_last;
        logic [15:0] exp_sr;
        rst_n    = r;
        in_valid = v;
        in_data  = d;
        ov  = sv_m;
        ob  = so_m;
        acc = v && (qm.size() <= 1);
        @(posedge clk);
        // downstream 16-bit serial-in shift register
        if (ov) sr = {sr[14:0], ob};
        if (qm.size() > 0) begin
            was_last = (qm.size() == 1);
            hist.push_back(qm[0]);
            if (hist.size() > 16) void'(hist.pop_front());
            if (was_last) begin
                exp_sr = '0;
                foreach (hist[i]) exp_sr = {exp_sr[14:0], hist[i]};
                chk("downstream_sr", sr, exp_sr);
                sr_at_done = sr;
            end
        end
        if (!r) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) push_word(d);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // reset state
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0000);

        // single word, known bit pattern
        step(1'b1, 1'b1, 16'hA5C3);
        idle(FL + 2);
`ifndef PISO_PARITY_EN
        chk("a5c3_sr", sr_at_done, 16'hA5C3);
`endif

        // back-to-back with in_valid held
        maxrun = 0;
        step(1'b1, 1'b1, 16'hFFFF);
        for (int i = 0; i < FL; i++) step(1'b1, 1'b1, 16'h0001);
        idle(FL + 2);
        chk("b2b_run", maxrun, 2 * FL);

        // offers while busy are refused; data changes ignored
        step(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < FL - 3; i++) step(1'b1, 1'b1, 16'h5678);
        idle(FL + 2);

        // reset mid-frame, then a fresh word
        step(1'b1, 1'b1, 16'hF0F0);
        idle(6);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'h8001);
        idle(FL + 2);

        // small words exercising bit order and parity
        step(1'b1, 1'b1, 16'h0003);
        idle(FL + 1);
        step(1'b1, 1'b1, 16'h0007);
        idle(FL + 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, W'($urandom));
        idle(FL + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
